// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply tile sequencing path.
package mm_pkg;

  localparam int C_ELEM_BYTES = 2;
  localparam int A_ELEM_BYTES = 1;

  localparam int DESC_DIM_W  = 16;
  localparam int DESC_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE
  } tile_state_e;

  typedef struct packed {
    logic [DESC_DIM_W-1:0]  row;
    logic [DESC_DIM_W-1:0]  col;
    logic [DESC_DIM_W-1:0]  rows;
    logic [DESC_DIM_W-1:0]  cols;
    logic [DESC_ADDR_W-1:0] addr_a;
    logic [DESC_ADDR_W-1:0] addr_b;
    logic [DESC_ADDR_W-1:0] addr_c;
  } tile_desc_t;

endpackage

// File: rtl/tile_scheduler_axis.sv
// One tiling axis: tile index, elements remaining, clamped extent and two
// address accumulators that step by increments captured at load time.
module tile_axis_counter #(
  parameter int DIM_WIDTH     = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int TILE          = 32
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     load,
  input  logic                     advance,
  input  logic [DIM_WIDTH-1:0]     load_count,
  input  logic [ADDRESS_WIDTH-1:0] load_addr0,
  input  logic [ADDRESS_WIDTH-1:0] load_addr1,
  input  logic [ADDRESS_WIDTH-1:0] load_step0,
  input  logic [ADDRESS_WIDTH-1:0] load_step1,
  output logic [DIM_WIDTH-1:0]     index_o,
  output logic [DIM_WIDTH-1:0]     extent_o,
  output logic [ADDRESS_WIDTH-1:0] addr0_o,
  output logic [ADDRESS_WIDTH-1:0] addr1_o,
  output logic                     is_last_o
);

  localparam logic [DIM_WIDTH-1:0] TILE_DIM = DIM_WIDTH'(TILE);

  logic [DIM_WIDTH-1:0]     index_q, index_d;
  logic [DIM_WIDTH-1:0]     left_q, left_d;
  logic [ADDRESS_WIDTH-1:0] addr0_q, addr0_d;
  logic [ADDRESS_WIDTH-1:0] addr1_q, addr1_d;
  logic [ADDRESS_WIDTH-1:0] step0_q, step0_d;
  logic [ADDRESS_WIDTH-1:0] step1_q, step1_d;

  // load restarts the axis at index 0; advance moves one tile along it
  always_comb begin
    index_d = index_q;
    left_d  = left_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    step0_d = step0_q;
    step1_d = step1_q;
    if (load) begin
      index_d = '0;
      left_d  = load_count;
      addr0_d = load_addr0;
      addr1_d = load_addr1;
      step0_d = load_step0;
      step1_d = load_step1;
    end else if (advance) begin
      index_d = index_q + 1'b1;
      left_d  = left_q - TILE_DIM;
      addr0_d = addr0_q + step0_q;
      addr1_d = addr1_q + step1_q;
    end
  end

  // axis registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      index_q <= '0;
      left_q  <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      step0_q <= '0;
      step1_q <= '0;
    end else begin
      index_q <= index_d;
      left_q  <= left_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      step0_q <= step0_d;
      step1_q <= step1_d;
    end
  end

  assign is_last_o = (left_q <= TILE_DIM);
  assign extent_o  = is_last_o ? left_q : TILE_DIM;
  assign index_o   = index_q;
  assign addr0_o   = addr0_q;
  assign addr1_o   = addr1_q;

endmodule

// File: rtl/tile_scheduler.sv
// Walks a C = A * B job over the systolic array one output tile at a time,
// column-inner order, handing each tile descriptor to the datapath.
//
// state | meaning
// IDLE  | waiting for start_i; rejects jobs with a zero dimension
// ISSUE | tile_start_o pulse; descriptor outputs valid
// WAIT  | datapath busy on the current tile
// NEXT  | step column (or wrap column and step row)
// DONE  | done_o pulse, then back to IDLE
module tile_scheduler
  import mm_pkg::*;
#(
  parameter int ARRAY_HEIGHT  = 32,
  parameter int ARRAY_WIDTH   = 4,
  parameter int DIM_WIDTH     = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [DIM_WIDTH-1:0]     m,
  input  logic [DIM_WIDTH-1:0]     n,
  input  logic [DIM_WIDTH-1:0]     p,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_a,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_b,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_c,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic                     tile_start_o,
  input  logic                     tile_done_i,
  output logic [DIM_WIDTH-1:0]     tile_row_o,
  output logic [DIM_WIDTH-1:0]     tile_col_o,
  output logic [DIM_WIDTH-1:0]     tile_rows_o,
  output logic [DIM_WIDTH-1:0]     tile_cols_o,
  output logic [ADDRESS_WIDTH-1:0] tile_addr_a_o,
  output logic [ADDRESS_WIDTH-1:0] tile_addr_b_o,
  output logic [ADDRESS_WIDTH-1:0] tile_addr_c_o
);

  // Array dimensions are powers of two, so per-row strides are plain shifts.
  localparam int H_SHIFT = $clog2(ARRAY_HEIGHT);
  localparam int C_SHIFT = $clog2(C_ELEM_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] COL_STEP_B = ADDRESS_WIDTH'(ARRAY_WIDTH * A_ELEM_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] COL_STEP_C = ADDRESS_WIDTH'(ARRAY_WIDTH * C_ELEM_BYTES);

  tile_state_e state_q, state_d;
  logic                     error_q, error_d;
  logic [DIM_WIDTH-1:0]     p_q, p_d;
  logic [ADDRESS_WIDTH-1:0] base_b_q, base_b_d;

  logic                     row_load, row_adv, col_load, col_adv;
  logic [DIM_WIDTH-1:0]     col_load_count;
  logic [ADDRESS_WIDTH-1:0] col_load_addr;
  logic [ADDRESS_WIDTH-1:0] step_a, step_c_row;
  logic                     row_last, col_last;
  logic [ADDRESS_WIDTH-1:0] row_addr_c, col_addr_c;

  assign step_a     = ADDRESS_WIDTH'(n) << H_SHIFT;
  assign step_c_row = ADDRESS_WIDTH'(p) << (H_SHIFT + C_SHIFT);

  // next-state and axis control
  always_comb begin
    state_d        = state_q;
    error_d        = 1'b0;
    p_d            = p_q;
    base_b_d       = base_b_q;
    row_load       = 1'b0;
    row_adv        = 1'b0;
    col_load       = 1'b0;
    col_adv        = 1'b0;
    col_load_count = p_q;
    col_load_addr  = base_b_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (m == '0 || n == '0 || p == '0) begin
            error_d = 1'b1;
          end else begin
            state_d        = ISSUE;
            p_d            = p;
            base_b_d       = base_addr_b;
            row_load       = 1'b1;
            col_load       = 1'b1;
            col_load_count = p;
            col_load_addr  = base_addr_b;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (tile_done_i) state_d = (row_last && col_last) ? DONE : NEXT;
      end
      NEXT: begin
        state_d = ISSUE;
        // column wrap reloads the column axis from the latched job values
        if (col_last) begin
          row_adv  = 1'b1;
          col_load = 1'b1;
        end else begin
          col_adv = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and latched job registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      error_q  <= 1'b0;
      p_q      <= '0;
      base_b_q <= '0;
    end else begin
      state_q  <= state_d;
      error_q  <= error_d;
      p_q      <= p_d;
      base_b_q <= base_b_d;
    end
  end

  // row axis: addr0 walks A, addr1 walks the C row base
  tile_axis_counter #(
    .DIM_WIDTH    (DIM_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .TILE         (ARRAY_HEIGHT)
  ) u_row_axis (
    .clk        (clk),
    .clear      (reset),
    .load       (row_load),
    .advance    (row_adv),
    .load_count (m),
    .load_addr0 (base_addr_a),
    .load_addr1 (base_addr_c),
    .load_step0 (step_a),
    .load_step1 (step_c_row),
    .index_o    (tile_row_o),
    .extent_o   (tile_rows_o),
    .addr0_o    (tile_addr_a_o),
    .addr1_o    (row_addr_c),
    .is_last_o  (row_last)
  );

  // column axis: addr0 walks B, addr1 is the C offset within the row band
  tile_axis_counter #(
    .DIM_WIDTH    (DIM_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .TILE         (ARRAY_WIDTH)
  ) u_col_axis (
    .clk        (clk),
    .clear      (reset),
    .load       (col_load),
    .advance    (col_adv),
    .load_count (col_load_count),
    .load_addr0 (col_load_addr),
    .load_addr1 ('0),
    .load_step0 (COL_STEP_B),
    .load_step1 (COL_STEP_C),
    .index_o    (tile_col_o),
    .extent_o   (tile_cols_o),
    .addr0_o    (tile_addr_b_o),
    .addr1_o    (col_addr_c),
    .is_last_o  (col_last)
  );

  assign tile_addr_c_o = row_addr_c + col_addr_c;
  assign tile_start_o  = (state_q == ISSUE);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign error_o       = error_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: a job-level model enqueues the expected
// tile descriptors, a monitor compares each tile_start_o against the queue.
module tb_tile_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] m = '0, n = '0, p = '0;
  logic [15:0] base_addr_a = '0, base_addr_b = '0, base_addr_c = '0;
  logic        busy_o, done_o, error_o, tile_start_o;
  logic        tile_done_i = 1'b0;
  logic [15:0] tile_row_o, tile_col_o, tile_rows_o, tile_cols_o;
  logic [15:0] tile_addr_a_o, tile_addr_b_o, tile_addr_c_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int row, col, rows, cols, a, b, c;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  tile_scheduler dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .m(m), .n(n), .p(p),
    .base_addr_a(base_addr_a), .base_addr_b(base_addr_b), .base_addr_c(base_addr_c),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .tile_start_o(tile_start_o), .tile_done_i(tile_done_i),
    .tile_row_o(tile_row_o), .tile_col_o(tile_col_o),
    .tile_rows_o(tile_rows_o), .tile_cols_o(tile_cols_o),
    .tile_addr_a_o(tile_addr_a_o), .tile_addr_b_o(tile_addr_b_o),
    .tile_addr_c_o(tile_addr_c_o)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enumerate tiles with plain arithmetic, row outer / col inner.
  function automatic int push_model(int mm, int nn, int pp, int a, int b, int c);
    int nr = (mm + 31) / 32;
    int nc = (pp + 3) / 4;
    for (int r = 0; r < nr; r++) begin
      for (int k = 0; k < nc; k++) begin
        exp_t e;
        e.row  = r;
        e.col  = k;
        e.rows = (mm - r * 32 < 32) ? mm - r * 32 : 32;
        e.cols = (pp - k * 4 < 4) ? pp - k * 4 : 4;
        e.a    = (a + r * 32 * nn) & 32'hFFFF;
        e.b    = (b + k * 4) & 32'hFFFF;
        e.c    = (c + 2 * (r * 32 * pp + k * 4)) & 32'hFFFF;
        exp_q.push_back(e);
      end
    end
    return nr * nc;
  endfunction

  // Monitor: every tile_start_o pops one expected descriptor.
  always @(negedge clk) begin
    if (tile_start_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tile_start: got row %0d col %0d, expected no tile", tile_row_o, tile_col_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (tile_row_o !== 16'(e.row) || tile_col_o !== 16'(e.col) ||
            tile_rows_o !== 16'(e.rows) || tile_cols_o !== 16'(e.cols) ||
            tile_addr_a_o !== 16'(e.a) || tile_addr_b_o !== 16'(e.b) ||
            tile_addr_c_o !== 16'(e.c)) begin
          errors++;
          $display("FAIL tile_desc: got (%0d,%0d) %0d/%0d a=%h b=%h c=%h expected (%0d,%0d) %0d/%0d a=%h b=%h c=%h",
                   tile_row_o, tile_col_o, tile_rows_o, tile_cols_o,
                   tile_addr_a_o, tile_addr_b_o, tile_addr_c_o,
                   e.row, e.col, e.rows, e.cols, e.a[15:0], e.b[15:0], e.c[15:0]);
        end
      end
    end
  end

  task automatic wait_tile_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tile_start_o) begin
        ok = 1'b1;
        return;
      end
    end
    check("tile_start_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {28'd0, busy_o, done_o, error_o, tile_start_o}, 0);
    check({name, "_idx"}, (tile_row_o | tile_col_o | tile_rows_o | tile_cols_o), 0);
    check({name, "_addr"}, (tile_addr_a_o | tile_addr_b_o | tile_addr_c_o), 0);
  endtask

  // mode 0: normal; 1: hold start_i high while busy; 2: tile_done_i during ISSUE.
  // abort_tile >= 0 asserts reset while that tile is in WAIT.
  task automatic run_job(input int mm, input int nn, input int pp,
                         input int a, input int b, input int c,
                         input int mode, input int abort_tile);
    int  ntiles;
    bit  ok;
    ntiles = push_model(mm, nn, pp, a, b, c);
    @(posedge clk); #1;
    m = 16'(mm); n = 16'(nn); p = 16'(pp);
    base_addr_a = 16'(a); base_addr_b = 16'(b); base_addr_c = 16'(c);
    start_i = 1'b1;
    @(posedge clk); #1;
    if (mode != 1) start_i = 1'b0;
    if (mode == 2) tile_done_i = 1'b1;
    @(negedge clk);
    check("start_latency", {31'd0, tile_start_o}, 1);
    check("busy_after_accept", {31'd0, busy_o}, 1);
    for (int k = 0; k < ntiles; k++) begin
      if (k > 0) begin
        wait_tile_start(ok);
        if (!ok) return;
      end
      if (mode == 2 && k == 0) begin
        @(posedge clk); #1;
        tile_done_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("done_in_issue_ignored", {30'd0, busy_o, done_o}, 2);
        end
      end
      if (k == abort_tile) begin
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("reset_mid_wait");
        repeat (3) begin
          @(negedge clk);
          check("no_done_after_abort", {30'd0, busy_o, done_o}, 0);
        end
        return;
      end
      @(posedge clk);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      tile_done_i = 1'b1;
      @(posedge clk); #1;
      tile_done_i = 1'b0;
      if (k == ntiles - 1) start_i = 1'b0;
      @(negedge clk);
      if (k == ntiles - 1) check("done_pulse", {30'd0, busy_o, done_o}, 3);
      else check("no_early_done", {31'd0, done_o}, 0);
    end
    @(negedge clk);
    check("done_single_cycle", {30'd0, busy_o, done_o}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // single tile
    run_job(32, 8, 4, 'h0100, 'h0200, 'h0400, 0, -1);
    // 2x2 tiles with partial row and column remainders
    run_job(40, 2, 6, 'h0100, 'h0200, 'h0400, 0, -1);

    // zero dimension rejected
    @(posedge clk); #1;
    m = 16'd8; n = 16'd0; p = 16'd4; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("error_pulse", {29'd0, error_o, busy_o, tile_start_o}, 4);
    @(negedge clk);
    check("error_single_cycle", {30'd0, error_o, busy_o}, 0);
    run_job(33, 3, 5, 'h0100, 'h0200, 'h0400, 0, -1);

    // start held high during the job, tile_done_i in ISSUE and IDLE
    run_job(64, 4, 8, 'h0100, 'h0200, 'h0400, 1, -1);
    run_job(32, 8, 4, 'h0100, 'h0200, 'h0400, 2, -1);
    @(posedge clk); #1;
    tile_done_i = 1'b1;
    @(posedge clk); #1;
    tile_done_i = 1'b0;
    @(negedge clk);
    check("done_in_idle_ignored", {30'd0, busy_o, done_o}, 0);

    // reset in WAIT of tile (0,1), then a fresh job
    run_job(40, 2, 6, 'h0100, 'h0200, 'h0400, 0, 1);
    run_job(40, 2, 6, 'h0100, 'h0200, 'h0400, 0, -1);

    // C address wrap
    run_job(64, 1, 8, 'h0100, 'h0200, 'hFFF0, 0, -1);

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      run_job($urandom_range(1, 100), $urandom_range(1, 50), $urandom_range(1, 20),
              $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF),
              $urandom_range(0, 16'hFFFF), 0, -1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
